// File: rtl/cmem_loader.sv
// Coefficient-memory write master: streams DEPTH coefficients into cmem in address order,
// then optionally reads them back and compares a modular checksum before raising done.
module cmem_loader #(
  parameter int DEPTH  = 64,
  parameter int AW     = 6,
  parameter int DW     = 16,
  parameter int VERIFY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic [AW-1:0] cm_addr,
  output logic          cm_w_en,
  output logic [DW-1:0] cm_data_in,
  input  logic [DW-1:0] cm_data_out,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [DW-1:0] checksum,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int            LAST_I  = DEPTH - 1;
  localparam logic [AW:0]   LAST    = LAST_I[AW:0];
  localparam logic [AW:0]   DEPTH_W = DEPTH[AW:0];

  state_t        state;
  logic [AW:0]   idx;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] rd_sum;
  logic [DW-1:0] rd_sum_nxt;
  logic          rd_vld0, rd_vld1;
  logic          rd_last0, rd_last1;
  logic          hs;

  // Stream handshake: a word transfers on a rising edge where s_valid && s_ready;
  // s_ready depends only on state, never on s_valid.
  assign s_ready    = (state == S_LOAD);
  assign hs         = s_valid & s_ready;
  assign busy       = (state == S_LOAD) || (state == S_VERIFY);
  assign dbg_state  = state;
  assign rd_sum_nxt = rd_sum + cm_data_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      rd_ptr     <= '0;
      rd_sum     <= '0;
      rd_vld0    <= 1'b0;
      rd_vld1    <= 1'b0;
      rd_last0   <= 1'b0;
      rd_last1   <= 1'b0;
      cm_addr    <= '0;
      cm_w_en    <= 1'b0;
      cm_data_in <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      checksum   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          cm_w_en  <= 1'b0;
          rd_vld0  <= 1'b0;
          rd_vld1  <= 1'b0;
          rd_last0 <= 1'b0;
          rd_last1 <= 1'b0;
          if (start) begin
            state    <= S_LOAD;
            done     <= 1'b0;
            error    <= 1'b0;
            idx      <= '0;
            rd_ptr   <= '0;
            checksum <= '0;
            rd_sum   <= '0;
          end else if (state == S_DONE) begin
            // Without readback, done rises the cycle after the last write is on cm_*.
            done <= 1'b1;
          end
        end

        S_LOAD: begin
          if (hs) begin
            cm_addr    <= idx[AW-1:0];
            cm_data_in <= s_data;
            cm_w_en    <= 1'b1;
            checksum   <= checksum + s_data;
            idx        <= idx + 1'b1;
            if (idx == LAST) begin
              state <= (VERIFY != 0) ? S_VERIFY : S_DONE;
            end
          end else begin
            cm_w_en <= 1'b0;
          end
        end

        S_VERIFY: begin
          // The first VERIFY cycle carries the final write, so reads start one edge later.
          cm_w_en <= 1'b0;
          if (rd_ptr < DEPTH_W) begin
            cm_addr  <= rd_ptr[AW-1:0];
            rd_ptr   <= rd_ptr + 1'b1;
            rd_vld0  <= 1'b1;
            rd_last0 <= (rd_ptr == LAST);
          end else begin
            rd_vld0  <= 1'b0;
            rd_last0 <= 1'b0;
          end
          rd_vld1  <= rd_vld0;
          rd_last1 <= rd_last0;
          if (rd_vld1) begin
            rd_sum <= rd_sum_nxt;
            if (rd_last1) begin
              error <= (rd_sum_nxt != checksum);
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmem_loader.sv
// Directed bench for cmem_loader: a readback instance and a no-readback instance share
// the stimulus, each backed by a synchronous-read cmem model.
module tb_cmem_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, s_valid;
  logic [DW-1:0] s_data;

  logic          s_ready_a, cm_w_en_a, busy_a, done_a, error_a;
  logic [AW-1:0] cm_addr_a;
  logic [DW-1:0] cm_data_in_a, cm_data_out_a, checksum_a;
  logic [1:0]    dbg_state_a;
  logic          s_ready_b, cm_w_en_b, busy_b, done_b, error_b;
  logic [AW-1:0] cm_addr_b;
  logic [DW-1:0] cm_data_in_b, cm_data_out_b, checksum_b;
  logic [1:0]    dbg_state_b;

  cmem_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .VERIFY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_a), .cm_addr(cm_addr_a), .cm_w_en(cm_w_en_a),
    .cm_data_in(cm_data_in_a), .cm_data_out(cm_data_out_a), .busy(busy_a),
    .done(done_a), .error(error_a), .checksum(checksum_a), .dbg_state(dbg_state_a)
  );

  cmem_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .VERIFY(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_b), .cm_addr(cm_addr_b), .cm_w_en(cm_w_en_b),
    .cm_data_in(cm_data_in_b), .cm_data_out(cm_data_out_b), .busy(busy_b),
    .done(done_b), .error(error_b), .checksum(checksum_b), .dbg_state(dbg_state_b)
  );

  // cmem models: write on edge, registered read one cycle after the address
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] rd_a, rd_b;
  logic          flip = 1'b0;

  always @(posedge clk) begin
    if (cm_w_en_a === 1'b1) mem_a[cm_addr_a] <= cm_data_in_a;
    rd_a <= mem_a[cm_addr_a] ^ ((flip && cm_addr_a == 6'd5) ? 16'h0001 : 16'h0000);
    if (cm_w_en_b === 1'b1) mem_b[cm_addr_b] <= cm_data_in_b;
    rd_b <= mem_b[cm_addr_b];
  end
  assign cm_data_out_a = rd_a;
  assign cm_data_out_b = rd_b;

  // scoreboard
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] obs_a[$];
  logic [AW+DW-1:0] obs_b[$];
  logic [AW-1:0]    rdq[$];
  int n_checks = 0;
  int n_errors = 0;
  int gap_err  = 0;

  always @(posedge clk) begin
    if (cm_w_en_a === 1'b1) obs_a.push_back({cm_addr_a, cm_data_in_a});
    if (cm_w_en_b === 1'b1) obs_b.push_back({cm_addr_b, cm_data_in_b});
    if (dbg_state_a == 2'd2 && cm_w_en_a === 1'b0) rdq.push_back(cm_addr_a);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic clear_sb();
    exp_q.delete(); obs_a.delete(); obs_b.delete(); rdq.delete();
  endtask

  task automatic start_load();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_word(input int i, input bit gap);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = 16'h1000 + i[DW-1:0];
    while (!s_ready_a && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("hs_wait", 32'd1, 32'd0);
    exp_q.push_back({i[AW-1:0], s_data});
    @(negedge clk);
    s_valid = 1'b0;
    if (gap) begin
      @(negedge clk);
      if (cm_w_en_a !== 1'b0) gap_err++;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic cmp_writes(input string tag, input int n, input bit use_b);
    int bad;
    int sz;
    bad = 0;
    sz  = use_b ? obs_b.size() : obs_a.size();
    if (sz != n) bad++;
    for (int k = 0; k < n && k < sz; k++) begin
      if ((use_b ? obs_b[k] : obs_a[k]) !== exp_q[k]) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int bad;
    rst_n = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;

    // 1: reset asserted mid-cycle clears outputs immediately
    #3 rst_n = 1'b0;
    #1;
    check("rst_s_ready", s_ready_a, 0);
    check("rst_w_en", cm_w_en_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done_err", {done_a, error_a, done_b, error_b}, 0);
    check("rst_cksum", checksum_a, 0);
    check("rst_addr", cm_addr_a, 0);
    @(negedge clk); rst_n = 1'b1;

    // 2: back-to-back stream of 16'h1000+i
    clear_sb();
    start_load();
    for (int i = 0; i < DEPTH; i++) send_word(i, 1'b0);
    // cycle after the last handshake: last write on cm_*, s_ready already low
    check("t2_last_wen", cm_w_en_a, 1);
    check("t2_last_addr", cm_addr_a, 63);
    check("t2_s_ready_low", s_ready_a, 0);
    check("t2_busy_verify", busy_a, 1);
    check("t6_b_done_early", done_b, 0);
    check("t6_b_busy", busy_b, 0);
    check("t6_b_last_wen", cm_w_en_b, 1);
    @(negedge clk);
    check("t6_b_done", done_b, 1);
    check("t6_b_wen_off", cm_w_en_b, 0);
    check("t6_b_cksum", checksum_b, 16'h07E0);
    check("t6_b_error", error_b, 0);
    wait_done(cyc);
    // done visible DEPTH+2 cycles after VERIFY entry; one cycle already consumed above
    check("t2_verify_len", cyc, DEPTH + 1);
    check("t2_done", done_a, 1);
    check("t2_error", error_a, 0);
    check("t2_cksum", checksum_a, 16'h07E0);
    cmp_writes("t2_writes", DEPTH, 1'b0);
    cmp_writes("t6_b_writes", DEPTH, 1'b1);
    bad = (rdq.size() < DEPTH) ? 1 : 0;
    for (int k = 0; k < DEPTH && k < rdq.size(); k++) if (rdq[k] != k[AW-1:0]) bad++;
    check("t2_read_seq", bad, 0);
    repeat (3) @(negedge clk);
    check("t2_done_held", done_a, 1);

    // 3: s_valid every other cycle
    clear_sb();
    gap_err = 0;
    start_load();
    check("t3_done_clr", done_a, 0);
    for (int i = 0; i < DEPTH; i++) send_word(i, 1'b1);
    wait_done(cyc);
    check("t3_done", done_a, 1);
    check("t3_error", error_a, 0);
    check("t3_cksum", checksum_a, 16'h07E0);
    check("t3_gap_wen", gap_err, 0);
    cmp_writes("t3_writes", DEPTH, 1'b0);

    // 4: corrupted readback of address 5
    clear_sb();
    flip = 1'b1;
    start_load();
    for (int i = 0; i < DEPTH; i++) send_word(i, 1'b0);
    wait_done(cyc);
    check("t4_done", done_a, 1);
    check("t4_error", error_a, 1);
    flip = 1'b0;

    // 5: start ignored mid-load, then reset mid-load, then clean reload
    clear_sb();
    start_load();
    for (int i = 0; i < 20; i++) begin
      if (i == 10) start = 1'b1;
      send_word(i, 1'b0);
      start = 1'b0;
    end
    check("t5_busy", busy_a, 1);
    check("t5_cksum20", checksum_a, 16'h40BE);
    @(posedge clk); #1;
    cmp_writes("t5_no_restart", 20, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy_a, 0);
    check("t5_rst_outs", {s_ready_a, cm_w_en_a, done_a, error_a}, 0);
    @(negedge clk); rst_n = 1'b1;
    clear_sb();
    start_load();
    send_word(0, 1'b0);
    check("t5_first_addr", cm_addr_a, 0);
    check("t5_first_wen", cm_w_en_a, 1);
    check("t5_first_data", cm_data_in_a, 16'h1000);
    for (int i = 1; i < DEPTH; i++) send_word(i, 1'b0);
    wait_done(cyc);
    check("t5_done", done_a, 1);
    check("t5_error", error_a, 0);
    check("t5_cksum", checksum_a, 16'h07E0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
